id_hazard_ctrl: RTL
===================

# id_hazard_ctrl

Hazard and forwarding controller for the decode stage. Tracks destination-register tags of in-flight instructions across EX, MM1, MM2 and WB. Drives the 3-bit forwarding selects consumed by the decode-stage operand forwarding muxes. Raises the decode stall for load-use hazards that no forwarding path can cover.

## Interface

Parameters:
- `CNT_W`, default 32: width of the load-use stall performance counter.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-high.
- `id_valid`  in  1: decode holds a valid instruction.
- `id_rj`, `id_rk`  in  5 each: source register numbers.
- `id_rj_used`, `id_rk_used`  in  1 each: the source is actually read.
- `id_dest`  in  5: destination register.
- `id_wen`  in  1: the instruction writes the GR file.
- `id_is_load`  in  1: the instruction is a load (data valid at MM2).
- `mem_stall`  in  1: downstream freeze (cache miss); all tags hold.
- `ex_flush`  in  1: branch redirect; kills the instruction entering EX.
- `fwd_rj`, `fwd_rk`  out  3 each: forwarding selects.
- `id_stall`  out  1: hold decode and insert a bubble into EX.
- `stall_cnt`  out  CNT_W: count of load-use stall cycles, saturating.

## Operation

- Four tag registers, one per stage: EX, MM1, MM2, WB.
  - Each holds `valid`, `dest[4:0]`, `wen`, `is_load`.
- A stage matches source `r` when all of these hold:
  - `valid && wen`
  - `dest == r`
  - `r != 0`
  - the source's `_used` bit is 1
- Select priority is youngest first: EX, MM1, MM2, WB.
- Select for the first matching stage:
  - EX non-load → `FWD_SRC_EX`.
  - MM1 non-load → `FWD_SRC_MM1`.
  - MM2 non-load → `FWD_SRC_MM2_REG`.
  - MM2 load → `FWD_SRC_MM2_MEM`.
  - WB → `FWD_SRC_WB`.
  - No match → `FWD_SRC_GR`.
- Load-use hazard: the first match for rj or rk is a load in EX or MM1. Then:
  - `id_stall = id_valid`.
  - The select output is don't-care; drive `FWD_SRC_GR`.
- Selects and `id_stall` are combinational from the tag registers and the current decode fields.
- Tag advance on each `clk` edge when `mem_stall == 0`:
  - WB ← MM2, MM2 ← MM1, MM1 ← EX.
  - EX ← decode fields, with `valid = id_valid && !id_stall && !ex_flush`.
- When `mem_stall == 1`, all tags hold. Exception: if `ex_flush` is also 1, EX.valid clears and the other fields hold.
- `stall_cnt` increments each cycle with `id_stall && !mem_stall`. It saturates at all-ones.

## Timing

- Reset values:
  - All tag valids = 0.
  - `stall_cnt` = 0.
  - Therefore `fwd_rj = fwd_rk = FWD_SRC_GR` (0) and `id_stall = 0`.
- Forwarding latency: 0 cycles. Selects are valid in the same cycle decode presents its sources.
- Load-use penalty, load immediately followed by a consumer:
  - 2 stall cycles while the load is in EX, then MM1.
  - Cycle 3: consumer issues with `FWD_SRC_MM2_MEM`.
- Load followed by one independent instruction, then the consumer: 1 stall cycle.
- A WB entry retires on the next advance.
- `reset` asserted mid-operation clears all tags immediately (asynchronous). The next cycle shows no forwarding.

## Structure

- `defs.v` holds the shared encodings:
  - `FWD_SRC_GR`=3'd0
  - `FWD_SRC_EX`=3'd1
  - `FWD_SRC_MM1`=3'd2
  - `FWD_SRC_MM2_REG`=3'd3
  - `FWD_SRC_MM2_MEM`=3'd4
  - `FWD_SRC_WB`=3'd5
- Tag field widths are also defined in `defs.v`.
- One sub-module: `fwd_src_sel`.
  - Combinational priority match for a single source operand.
  - Produces a 3-bit select plus a `load_hit` flag.
  - Instantiated twice, for rj and rk.

## Test plan

- **Back-to-back ALU dependency.** `add r5` then `use rj=r5` → `fwd_rj=1`; next cycle MM1 → `2`; then `3`, then `5`, then `0`.
- **Load-use.** Load r7, then consumer with `rk=r7` → `id_stall=1` for 2 cycles; `stall_cnt=2`; third cycle `fwd_rk=4`, `id_stall=0`.
- **r0 and unused source.** Producer dest r0, and `rj_used=0` matching dest → both selects 0, no stall.
- **Priority.** r3 written in both EX and WB → `fwd_rj=1`. Two loads to r3 in EX and MM2 → stall.
- **Freeze and flush.** `mem_stall=1` for 3 cycles → selects and tags unchanged. `ex_flush` with a load in decode → no EX tag and no subsequent stall.
- **Reset.** Assert `reset` while the pipeline is full → all selects 0, `id_stall=0`, `stall_cnt=0` immediately.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared encodings and tag types for the decode-stage hazard/forwarding
// controller.
//   - fwd_src_e : forwarding select driven to the decode operand muxes
//   - tag_t     : destination tag carried by each in-flight stage
//   - STG_*     : index of each stage inside the packed tag array
package id_hazard_ctrl_pkg;

    localparam int REG_W   = 5;   // GR number width
    localparam int FWD_W   = 3;   // forwarding select width
    localparam int NUM_STG = 4;   // EX, MM1, MM2, WB

    localparam int STG_EX  = 0;
    localparam int STG_MM1 = 1;
    localparam int STG_MM2 = 2;
    localparam int STG_WB  = 3;

    typedef enum logic [FWD_W-1:0] {
        FWD_SRC_GR      = 3'd0,
        FWD_SRC_EX      = 3'd1,
        FWD_SRC_MM1     = 3'd2,
        FWD_SRC_MM2_REG = 3'd3,
        FWD_SRC_MM2_MEM = 3'd4,
        FWD_SRC_WB      = 3'd5
    } fwd_src_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wen;
        logic             is_load;
    } tag_t;

    // Index 0 is the youngest stage (EX).
    typedef tag_t [NUM_STG-1:0] tag_arr_t;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decode-side bundle of the hazard controller.
//   master : decode stage / environment (drives instruction fields and
//            pipeline controls, receives selects, stall and counter)
//   slave  : id_hazard_ctrl
interface id_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import id_hazard_ctrl_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rj;
    logic [REG_W-1:0] id_rk;
    logic             id_rj_used;
    logic             id_rk_used;
    logic [REG_W-1:0] id_dest;
    logic             id_wen;
    logic             id_is_load;
    logic             mem_stall;
    logic             ex_flush;
    logic [FWD_W-1:0] fwd_rj;
    logic [FWD_W-1:0] fwd_rk;
    logic             id_stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rj, id_rk, id_rj_used, id_rk_used,
               id_dest, id_wen, id_is_load, mem_stall, ex_flush,
        input  fwd_rj, fwd_rk, id_stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rj, id_rk, id_rj_used, id_rk_used,
               id_dest, id_wen, id_is_load, mem_stall, ex_flush,
        output fwd_rj, fwd_rk, id_stall, stall_cnt
    );

endinterface

// File: rtl/id_hazard_ctrl_fwd_src_sel.sv
// Priority forwarding match for one decode source operand.
//   src_i      : source register number
//   used_i     : source is actually read
//   tags_i     : in-flight tags, index 0 = EX (youngest) .. 3 = WB
//   sel_o      : forwarding select for the youngest matching stage
//   load_hit_o : youngest match is a load still in EX or MM1
module fwd_src_sel
    import id_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic             used_i,
    input  tag_arr_t         tags_i,
    output fwd_src_e         sel_o,
    output logic             load_hit_o
);

    function automatic fwd_src_e stage_sel(input int stg, input logic ld);
        fwd_src_e s;
        case (stg)
            STG_EX:  s = ld ? FWD_SRC_GR : FWD_SRC_EX;
            STG_MM1: s = ld ? FWD_SRC_GR : FWD_SRC_MM1;
            STG_MM2: s = ld ? FWD_SRC_MM2_MEM : FWD_SRC_MM2_REG;
            default: s = FWD_SRC_WB;
        endcase
        return s;
    endfunction

    // Walk oldest to youngest so the youngest match is the one that sticks.
    always_comb begin
        sel_o      = FWD_SRC_GR;
        load_hit_o = 1'b0;
        for (int i = NUM_STG - 1; i >= 0; i--) begin
            if (used_i && (src_i != '0) && tags_i[i].valid && tags_i[i].wen &&
                (tags_i[i].dest == src_i)) begin
                load_hit_o = tags_i[i].is_load && (i <= STG_MM1);
                sel_o      = stage_sel(i, tags_i[i].is_load);
            end
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard and forwarding controller.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : decode fields, mem_stall/ex_flush in; fwd_rj/fwd_rk,
//                id_stall and the saturating load-use stall counter out
// Tracks destination tags across EX, MM1, MM2, WB and stalls decode on
// load-use hazards that no forwarding path can cover.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    id_hazard_ctrl_if.slave   bus
);

    tag_arr_t         tags_q, tags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    fwd_src_e sel_rj, sel_rk;
    logic     ld_hit_rj, ld_hit_rk;
    logic     hazard;
    logic     stall;

    fwd_src_sel u_sel_rj (
        .src_i      (bus.id_rj),
        .used_i     (bus.id_rj_used),
        .tags_i     (tags_q),
        .sel_o      (sel_rj),
        .load_hit_o (ld_hit_rj)
    );

    fwd_src_sel u_sel_rk (
        .src_i      (bus.id_rk),
        .used_i     (bus.id_rk_used),
        .tags_i     (tags_q),
        .sel_o      (sel_rk),
        .load_hit_o (ld_hit_rk)
    );

    // Under a load-use hazard the selects are irrelevant; park them on GR.
    assign hazard        = ld_hit_rj || ld_hit_rk;
    assign stall         = bus.id_valid && hazard;
    assign bus.id_stall  = stall;
    assign bus.fwd_rj    = hazard ? FWD_SRC_GR : sel_rj;
    assign bus.fwd_rk    = hazard ? FWD_SRC_GR : sel_rk;
    assign bus.stall_cnt = cnt_q;

    // Tag advance: a stalled or flushed decode slot enters EX as a bubble.
    // During a freeze everything holds, but a flush still kills EX.
    always_comb begin
        tags_d = tags_q;
        if (!bus.mem_stall) begin
            tags_d[STG_WB]  = tags_q[STG_MM2];
            tags_d[STG_MM2] = tags_q[STG_MM1];
            tags_d[STG_MM1] = tags_q[STG_EX];
            tags_d[STG_EX]  = '{valid:   bus.id_valid && !stall && !bus.ex_flush,
                                dest:    bus.id_dest,
                                wen:     bus.id_wen,
                                is_load: bus.id_is_load};
        end else if (bus.ex_flush) begin
            tags_d[STG_EX].valid = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !bus.mem_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tags_q <= '0;
            cnt_q  <= '0;
        end else begin
            tags_q <= tags_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
